// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals shared by alu_arbiter and its environment.
// The master modport is the requester/ALU side; the slave modport is the arbiter itself.
interface alu_arbiter_if #(
   parameter int W = 32
);
   logic          req0;
   logic          req1;
   logic [2:0]    op0;
   logic [2:0]    op1;
   logic [W-1:0]  a0;
   logic [W-1:0]  a1;
   logic [W-1:0]  b0;
   logic [W-1:0]  b1;
   logic          gnt0;
   logic          gnt1;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [W-1:0]  alu_r;
   logic          alu_c;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [W-1:0]  rsp_data;
   logic          rsp_carry;
   logic          busy;

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1,
      output alu_r, alu_c, rsp_ready,
      input  gnt0, gnt1, alu_op, alu_a, alu_b,
      input  rsp_valid, rsp_id, rsp_data, rsp_carry, busy
   );

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1,
      input  alu_r, alu_c, rsp_ready,
      output gnt0, gnt1, alu_op, alu_a, alu_b,
      output rsp_valid, rsp_id, rsp_data, rsp_carry, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer in front of a registered ALU (one cycle latency).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e        state_q;
   state_e        state_d;
   logic [2:0]    alu_op_q;
   logic [2:0]    alu_op_d;
   logic [W-1:0]  alu_a_q;
   logic [W-1:0]  alu_a_d;
   logic [W-1:0]  alu_b_q;
   logic [W-1:0]  alu_b_d;
   logic          rsp_id_q;
   logic          rsp_id_d;
   logic [W-1:0]  rsp_data_q;
   logic [W-1:0]  rsp_data_d;
   logic          rsp_carry_q;
   logic          rsp_carry_d;
   logic          rsp_valid_q;
   logic          rsp_valid_d;
   logic          busy_q;
   logic          busy_d;

   logic          idle_s;
   logic          any_req_s;
   logic          win1_s;
   logic          issue_s;

   assign idle_s    = (state_q == IDLE);
   assign any_req_s = bus.req0 | bus.req1;
   assign issue_s   = idle_s & any_req_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // requester 0 takes every tie, so 1 only wins when it requests alone
   always_comb begin
      win1_s = bus.req1 & ~bus.req0;
   end
`else
   logic          last_q;
   logic          last_d;

   // on a tie the requester that did not win last time is chosen
   always_comb begin
      if (bus.req0 && bus.req1) begin
         win1_s = ~last_q;
      end else begin
         win1_s = bus.req1;
      end
   end

   always_comb begin
      if (issue_s) begin
         last_d = win1_s;
      end else begin
         last_d = last_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign bus.gnt0 = issue_s & ~win1_s;
   assign bus.gnt1 = issue_s &  win1_s;

   always_comb begin
      state_d     = state_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               state_d = EXEC;
               busy_d  = 1'b1;
               if (win1_s) begin
                  alu_op_d = bus.op1;
                  alu_a_d  = bus.a1;
                  alu_b_d  = bus.b1;
                  rsp_id_d = 1'b1;
               end else begin
                  alu_op_d = bus.op0;
                  alu_a_d  = bus.a0;
                  alu_b_d  = bus.b0;
                  rsp_id_d = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // the ALU output register loads at the end of this cycle
            state_d = CAPT;
         end
         CAPT: begin
            state_d     = RESP;
            rsp_data_d  = bus.alu_r;
            rsp_carry_d = bus.alu_c;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // sequencer state and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_op_q    <= 3'd0;
         alu_a_q     <= {W{1'b0}};
         alu_b_q     <= {W{1'b0}};
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= {W{1'b0}};
         rsp_carry_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_carry = rsp_carry_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU in front of rsp port.
module tb_alu_arbiter;
   localparam int W = 32;

   logic        clk;
   logic        rst_n;
   int          cyc     = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [33:0] sb_q[$];
   logic [33:0] exp_e;
   int          gnt_cyc_q[$];
   logic        gnt_id_q[$];

   alu_arbiter_if #(.W(W)) bus();

   alu_arbiter #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, a} + {1'b0, b};
         3'd3:    return {1'b0, a} - {1'b0, b};
         3'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // shared ALU: result and carry registered, no reset
   always @(posedge clk) {bus.alu_c, bus.alu_r} <= alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

   // monitor: push expectation on grant, compare on response handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.gnt0 && bus.gnt1) chk("gnt_excl", 64'd3, 64'd0);
         if ((bus.gnt0 || bus.gnt1) && bus.busy) chk("gnt_busy", 64'd1, 64'd0);
         if (bus.rsp_valid && sb_q.size() == 0) chk("stale_rsp", 64'd1, 64'd0);
         if (bus.gnt0 || bus.gnt1) begin
            gnt_cyc_q.push_back(cyc);
            gnt_id_q.push_back(bus.gnt1);
            if (bus.gnt1) sb_q.push_back({1'b1, alu_fn(bus.op1, bus.a1, bus.b1)});
            else          sb_q.push_back({1'b0, alu_fn(bus.op0, bus.a0, bus.b0)});
         end
         if (bus.rsp_valid && bus.rsp_ready && sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            chk("sb_id",    64'(bus.rsp_id),    64'(exp_e[33]));
            chk("sb_carry", 64'(bus.rsp_carry), 64'(exp_e[32]));
            chk("sb_data",  64'(bus.rsp_data),  64'(exp_e[31:0]));
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_gnt0"},  64'(bus.gnt0),      64'd0);
      chk({tag, "_gnt1"},  64'(bus.gnt1),      64'd0);
      chk({tag, "_op"},    64'(bus.alu_op),    64'd0);
      chk({tag, "_a"},     64'(bus.alu_a),     64'd0);
      chk({tag, "_b"},     64'(bus.alu_b),     64'd0);
      chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_id"},    64'(bus.rsp_id),    64'd0);
      chk({tag, "_data"},  64'(bus.rsp_data),  64'd0);
      chk({tag, "_carry"}, 64'(bus.rsp_carry), 64'd0);
      chk({tag, "_busy"},  64'(bus.busy),      64'd0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit seen = 1'b0;
      @(posedge clk);
      #1;
      if (id) begin
         bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
      end else begin
         bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
      end
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         seen = id ? bus.gnt1 : bus.gnt0;
      end
      chk("issue_gnt", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      if (id) bus.req1 = 1'b0;
      else    bus.req0 = 1'b0;
   endtask

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         seen = bus.rsp_valid;
      end
      chk("valid_timeout", 64'(seen), 64'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         done = !bus.busy && !bus.rsp_valid;
      end
      chk("idle_timeout", 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.op0 = 3'd0;  bus.op1 = 3'd0;
      bus.a0 = 32'd0;  bus.a1 = 32'd0;
      bus.b0 = 32'd0;  bus.b1 = 32'd0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // single request: grant, operand timing, response at cycle 3
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'd5; bus.b0 = 32'd7;
      @(negedge clk);
      chk("t1_gnt0", 64'(bus.gnt0), 64'd1);
      chk("t1_gnt1", 64'(bus.gnt1), 64'd0);
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("t1_op",     64'(bus.alu_op),    64'd2);
      chk("t1_a",      64'(bus.alu_a),     64'd5);
      chk("t1_b",      64'(bus.alu_b),     64'd7);
      chk("t1_busy",   64'(bus.busy),      64'd1);
      chk("t1_vld_c1", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      chk("t1_vld_c2", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      chk("t1_vld_c3", 64'(bus.rsp_valid), 64'd1);
      chk("t1_data",   64'(bus.rsp_data),  64'd12);
      chk("t1_id",     64'(bus.rsp_id),    64'd0);
      @(negedge clk);
      chk("t1_idle",   64'(bus.busy),      64'd0);

      // contention with both requests held
      do_reset();
      gnt_cyc_q.delete();
      gnt_id_q.delete();
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      bus.req0 = 1'b1; bus.op0 = 3'd1; bus.a0 = 32'h1234_0000; bus.b0 = 32'h0000_5678;
      bus.req1 = 1'b1; bus.op1 = 3'd3; bus.a1 = 32'd10;        bus.b1 = 32'd20;
      for (int i = 0; i < 40 && gnt_id_q.size() < 4; i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      wait_idle();
      chk("cont_count", 64'(gnt_id_q.size()), 64'd4);
      for (int i = 0; i < gnt_id_q.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         chk("cont_id", 64'(gnt_id_q[i]), 64'd0);
`else
         chk("cont_id", 64'(gnt_id_q[i]), 64'(i % 2));
`endif
         if (i > 0) chk("cont_gap", 64'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 64'd4);
      end

      // backpressure: response held while req1 waits
      bus.rsp_ready = 1'b0;
      issue(1'b0, 3'd4, 32'hA5A5_0F0F, 32'h0FF0_1234);
      bus.req1 = 1'b1; bus.op1 = 3'd3; bus.a1 = 32'd100; bus.b1 = 32'd30;
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
         chk("bp_data",  64'(bus.rsp_data),  64'hAA55_1D3B);
         chk("bp_gnt1",  64'(bus.gnt1),      64'd0);
         chk("bp_busy",  64'(bus.busy),      64'd1);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_gnt1", 64'(bus.gnt1), 64'd0);
      @(negedge clk);
      chk("bp_post_gnt1", 64'(bus.gnt1), 64'd1);
      @(posedge clk);
      #1;
      bus.req1 = 1'b0;
      wait_idle();

      // carry out of the adder
      issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd1);
      wait_valid();
      chk("carry_data", 64'(bus.rsp_data),  64'd0);
      chk("carry_c",    64'(bus.rsp_carry), 64'd1);
      wait_idle();

      // reset asserted during CAPT
      issue(1'b0, 3'd1, 32'h0F0F_0000, 32'h0000_00FF);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_reset_vals("mid");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(1'b1, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_valid();
      chk("mid_id",   64'(bus.rsp_id),   64'd1);
      chk("mid_data", 64'(bus.rsp_data), 64'hF000_F000);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single registered ALU datapath (ALU plus its output register, one cycle of latency) between two requesters, e.g. the instruction-execute path and the PC/address-increment path of the multicycle processor. It accepts one operation at a time, drives the ALU operation code and operands, waits out the ALU output-register latency, then returns the result, carry and requester ID through a valid/ready response port.

## Interface
- W, 32, datapath width; must match the shared ALU's W.
- clk  in  1  rising-edge clock; same clock as the ALU output register.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held high with operands stable until granted.
- op0 / op1  in  3  ALUOp for requester 0 / 1.
- a0 / a1  in  W  first operand (to ALU R2).
- b0 / b1  in  W  second operand (to ALU R3).
- gnt0 / gnt1  out  1  grant; combinational, one-cycle pulse.
- alu_op  out  3  to ALU ALUOp; registered.
- alu_a / alu_b  out  W  to ALU R2 / R3; registered.
- alu_r  in  W  from ALU R0 (registered result).
- alu_c  in  1  from ALU c_out (registered carry).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  W  result.
- rsp_carry  out  1  carry out.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: if req0 or req1, the winner's gnt goes high in the same cycle. At the edge: winner's op/a/b are latched into alu_op/alu_a/alu_b, the winner's ID is stored in rsp_id, last-winner is updated, and the state moves to EXEC. With no request, the state stays IDLE.
- EXEC: operands sit on the ALU inputs. The ALU output register captures at the edge. The state moves to CAPT.
- CAPT: alu_r and alu_c are valid. They are latched into rsp_data and rsp_carry at the edge. The state moves to RESP.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_carry are held stable. At an edge with rsp_ready=1, the state moves to IDLE; otherwise it stays in RESP indefinitely.
- Arbitration: round-robin. With both requests high, the grant goes to the requester that did not win last. With a single request, that requester is granted regardless of history. last-winner resets to 1, so requester 0 wins the first contention.
- gnt0 and gnt1 are never both high. Both are 0 outside IDLE, even if req is high.
- alu_op, alu_a and alu_b retain the last issued values until the next grant.
- No arithmetic in this block. Widths pass through unchanged.

## Timing
- Reset values: state=IDLE, gnt0=gnt1=0, alu_op=0, alu_a=alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, busy=0, last-winner=1.
- Grant in cycle N: alu_* are valid from cycle N+1, and rsp_valid rises at the start of cycle N+3.
- Minimum issue interval: 4 cycles (grant, EXEC, CAPT, RESP with rsp_ready=1). The next grant can occur in the cycle after the RESP handshake edge.
- No request is granted in the cycle in which the RESP handshake completes.
- Requests that arrive while busy are not dropped. They are granted once the state returns to IDLE, provided req is still high.
- Reset mid-operation: all registers return to reset values immediately, and the in-flight result is discarded. The ALU output register has no reset, so its stale contents are ignored because the FSM restarts in IDLE.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both request, and last-winner is unused.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Test plan
- Reset then single request: req0=1, op0=3'b010, a0=5, b0=7. Required: gnt0 pulses in cycle 0; alu_op=2, alu_a=5, alu_b=7 in cycle 1; rsp_valid=1 with rsp_id=0, rsp_data equal to the ALU result, and rsp_carry equal to the ALU carry from cycle 3; rsp_ready=1 returns to IDLE.
- Contention: req0=req1=1, held continuously, with rsp_ready tied high. Required: grants alternate 0,1,0,1 exactly 4 cycles apart, and rsp_id alternates to match. With ALU_ARB_FIXED_PRIO_EN defined: always 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while req1=1. Required: rsp_valid and rsp_data are held stable, gnt1=0 and busy=1 throughout; gnt1 pulses in the cycle after the handshake.
- Carry path: op = add, a=32'hFFFF_FFFF, b=1. Required: rsp_data=0 and rsp_carry=1.
- Reset mid-operation: assert rst_n=0 during CAPT. Required: all outputs immediately take their reset values; after release, a fresh req1 is granted with rsp_id=1 and no stale response is seen.
